// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the main-RAM arbiter and the RAM it fronts.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 8;

  // Read-return owner tag: tells which master the RAM data belongs to.
  typedef logic [1:0] owner_t;
  localparam owner_t OWNER_NONE = 2'd0;
  localparam owner_t OWNER_A    = 2'd1;
  localparam owner_t OWNER_B    = 2'd2;

  // Width of the starvation counter: enough to hold STARVE_LIMIT, never zero.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One master's request/grant/read-return bundle toward the RAM arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = mem_arb_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_arb_pkg::DEF_DATA_WIDTH
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  stall;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, stall
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, stall
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port main RAM. Port A (CPU) has
// priority; port B wins one grant after STARVE_LIMIT consecutive lost
// cycles. Grants are combinational, read returns are tagged one cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arbiter_if.slave          a_if,
  mem_arbiter_if.slave          b_if,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int              CNT_W   = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  owner_t           owner_q, owner_d;
  logic             starve_hit;
  logic             a_gnt, b_gnt;
  logic             a_rvalid, b_rvalid;

  // A limit of zero disables the override entirely (A strict priority).
  assign starve_hit = (STARVE_LIMIT != 0) && (wait_cnt_q == LIMIT_C);

  // Winner selection; nothing is granted while reset is held.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (b_if.req && (!a_if.req || starve_hit)) begin
        b_gnt = 1'b1;
      end else if (a_if.req) begin
        a_gnt = 1'b1;
      end
    end
  end

  // RAM bus mux from the winner; idle bus is all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_gnt) begin
      mem_en    = 1'b1;
      mem_we    = a_if.we;
      mem_addr  = a_if.addr;
      mem_wdata = a_if.wdata;
    end else if (b_gnt) begin
      mem_en    = 1'b1;
      mem_we    = b_if.we;
      mem_addr  = b_if.addr;
      mem_wdata = b_if.wdata;
    end
  end

  // Next owner tag: only a granted read expects data back next cycle.
  always_comb begin
    owner_d = OWNER_NONE;
    if (a_gnt && !a_if.we) begin
      owner_d = OWNER_A;
    end else if (b_gnt && !b_if.we) begin
      owner_d = OWNER_B;
    end
  end

  // Consecutive-loss counter for B: saturates at the limit, clears on grant or idle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (b_gnt || !b_if.req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT_C) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWNER_NONE;
      wait_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A read in flight when reset arrives is dropped, hence the rst gating.
  assign a_rvalid = (owner_q == OWNER_A) && !rst;
  assign b_rvalid = (owner_q == OWNER_B) && !rst;

  assign a_if.gnt    = a_gnt;
  assign a_if.rvalid = a_rvalid;
  assign a_if.rdata  = a_rvalid ? mem_rdata : '0;
  assign a_if.stall  = a_if.req & ~a_gnt;

  assign b_if.gnt    = b_gnt;
  assign b_if.rvalid = b_rvalid;
  assign b_if.rdata  = b_rvalid ? mem_rdata : '0;
  assign b_if.stall  = b_if.req & ~b_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, every cycle
// compared against a per-cycle behavioural model with its own shadow memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int DW    = DEF_DATA_WIDTH;
  localparam int LIMIT = 8;

  logic clk;
  logic rst;

  mem_arbiter_if a_bus ();
  mem_arbiter_if b_bus ();
  mem_arbiter_if a0_bus ();
  mem_arbiter_if b0_bus ();

  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          m0_en, m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .a_if(a_bus), .b_if(b_bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0)) dut0 (
    .clk(clk), .rst(rst), .a_if(a0_bus), .b_if(b0_bus),
    .mem_en(m0_en), .mem_we(m0_we), .mem_addr(m0_addr),
    .mem_wdata(m0_wdata), .mem_rdata(8'h00)
  );

  // Simple synchronous single-port RAM, 1-cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            lost      = 0;
  int            ret_owner = 0;   // 0 none, 1 A, 2 B
  logic [DW-1:0] ret_data  = '0;
  bit            last_ea, last_eb;
  bit            obs_b_gnt, obs_a_rvalid, obs_b_rvalid;
  logic [DW-1:0] obs_a_rdata, obs_b_rdata;
  int            cyc = 0;

  // One clock: check all outputs at negedge, advance the model, return at posedge+1.
  task automatic step();
    bit ea, eb, starve;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    starve = (LIMIT != 0) && (lost >= LIMIT);
    ea = 0; eb = 0;
    if (!rst) begin
      if (b_bus.req && (!a_bus.req || starve)) eb = 1;
      else if (a_bus.req) ea = 1;
    end
    e_en = ea | eb; e_we = 0; e_addr = '0; e_wd = '0;
    if (ea) begin e_we = a_bus.we; e_addr = a_bus.addr; e_wd = a_bus.wdata; end
    if (eb) begin e_we = b_bus.we; e_addr = b_bus.addr; e_wd = b_bus.wdata; end

    check_val("a_gnt",     a_bus.gnt,   ea);
    check_val("b_gnt",     b_bus.gnt,   eb);
    check_val("mem_en",    mem_en,      e_en);
    check_val("mem_we",    mem_we,      e_we);
    check_val("mem_addr",  mem_addr,    e_addr);
    check_val("mem_wdata", mem_wdata,   e_wd);
    check_val("a_stall",   a_bus.stall, a_bus.req && !ea);
    check_val("b_stall",   b_bus.stall, b_bus.req && !eb);
    check_val("a_rvalid",  a_bus.rvalid, (ret_owner == 1) && !rst);
    check_val("b_rvalid",  b_bus.rvalid, (ret_owner == 2) && !rst);
    check_val("a_rdata",   a_bus.rdata, ((ret_owner == 1) && !rst) ? ret_data : 8'h00);
    check_val("b_rdata",   b_bus.rdata, ((ret_owner == 2) && !rst) ? ret_data : 8'h00);
    // Strict-priority instance: B only ever gets an idle A.
    check_val("s0_a_gnt",  a0_bus.gnt,  !rst && a0_bus.req);
    check_val("s0_b_gnt",  b0_bus.gnt,  !rst && b0_bus.req && !a0_bus.req);

    obs_b_gnt    = b_bus.gnt;
    obs_a_rvalid = a_bus.rvalid;
    obs_b_rvalid = b_bus.rvalid;
    obs_a_rdata  = a_bus.rdata;
    obs_b_rdata  = b_bus.rdata;

    if (rst) begin
      lost = 0;
      ret_owner = 0;
    end else begin
      if (b_bus.req && !eb) lost = (lost < LIMIT) ? lost + 1 : LIMIT;
      else lost = 0;
      ret_owner = 0;
      if (ea) begin
        if (a_bus.we) shadow[a_bus.addr] = a_bus.wdata;
        else begin ret_owner = 1; ret_data = shadow[a_bus.addr]; end
      end
      if (eb) begin
        if (b_bus.we) shadow[b_bus.addr] = b_bus.wdata;
        else begin ret_owner = 2; ret_data = shadow[b_bus.addr]; end
      end
    end
    last_ea = ea;
    last_eb = eb;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit req, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_bus.req = req; a_bus.we = we; a_bus.addr = addr; a_bus.wdata = wd;
  endtask

  task automatic set_b(input bit req, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    b_bus.req = req; b_bus.we = we; b_bus.addr = addr; b_bus.wdata = wd;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 15'h0010;
      1: return 15'h0020;
      2: return 15'h1234;
      3: return 15'h7FFF;
      default: return AW'($urandom_range(0, 63));
    endcase
  endfunction

  int b_cycles[$];
  bit a_act, b_act;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = DW'(i * 7 + 3);
      shadow[i] = DW'(i * 7 + 3);
    end
    ram[15'h1234] = 8'h5A; shadow[15'h1234] = 8'h5A;
    ram[15'h0010] = 8'h11; shadow[15'h0010] = 8'h11;
    ram[15'h0020] = 8'h22; shadow[15'h0020] = 8'h22;
    ram_q = '0;
    a0_bus.we = 0; a0_bus.addr = '0; a0_bus.wdata = '0;
    b0_bus.we = 0; b0_bus.addr = '0; b0_bus.wdata = '0;
    a0_bus.req = 1; b0_bus.req = 1;

    // Reset held with both masters requesting.
    rst = 1;
    set_a(1, 0, 15'h0001, 8'h00);
    set_b(1, 0, 15'h0002, 8'h00);
    repeat (3) step();
    rst = 0;
    step();
    check_val("rel_first_a", last_ea, 1'b1);

    // Lone A read of $1234.
    set_b(0, 0, '0, '0);
    set_a(0, 0, '0, '0);
    step();
    set_a(1, 0, 15'h1234, 8'h00);
    step();
    set_a(0, 0, '0, '0);
    step();
    check_val("a1234_rdata", obs_a_rdata, 8'h5A);
    check_val("a1234_brv",   obs_b_rvalid, 1'b0);

    // Continuous contention: B wins every LIMIT+1 cycles.
    set_a(1, 0, 15'h0100, 8'h00);
    set_b(1, 0, 15'h0200, 8'h00);
    for (int i = 0; i < 3 * (LIMIT + 1); i++) begin
      step();
      if (obs_b_gnt) b_cycles.push_back(i);
    end
    check_val("starve_cnt", b_cycles.size(), 3);
    if (b_cycles.size() > 0) check_val("starve_first", b_cycles[0], LIMIT);
    for (int i = 1; i < b_cycles.size(); i++)
      check_val("starve_period", b_cycles[i] - b_cycles[i-1], LIMIT + 1);
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    step();

    // Alternating back-to-back reads.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin set_a(1, 0, 15'h0010, 0); set_b(0, 0, 0, 0); end
      else            begin set_a(0, 0, 0, 0); set_b(1, 0, 15'h0020, 0); end
      step();
      if (i > 0 && i % 2 == 1) check_val("alt_a_rdata", obs_a_rdata, 8'h11);
      if (i > 0 && i % 2 == 0) check_val("alt_b_rdata", obs_b_rdata, 8'h22);
    end
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    step();
    check_val("alt_b_last", obs_b_rdata, 8'h22);

    // B write top address, then A reads it back.
    set_b(1, 1, 15'h7FFF, 8'hA5);
    step();
    check_val("bw_no_rvalid_next", last_eb, 1'b1);
    set_b(0, 0, 0, 0);
    set_a(1, 0, 15'h7FFF, 8'h00);
    step();
    check_val("bw_brv", obs_b_rvalid, 1'b0);
    set_a(0, 0, 0, 0);
    step();
    check_val("a7fff_rdata", obs_a_rdata, 8'hA5);

    // Read granted, reset the following cycle: data must be dropped.
    set_a(1, 0, 15'h1234, 8'h00);
    step();
    set_a(0, 0, 0, 0);
    rst = 1;
    step();
    check_val("rst_drop_rv", obs_a_rvalid, 1'b0);
    rst = 0;
    step();
    check_val("post_rst_rv", obs_a_rvalid, 1'b0);

    // Random traffic with occasional reset pulses.
    a_act = 0; b_act = 0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!a_act && $urandom_range(0, 99) < 60)
        begin a_act = 1; set_a(1, $urandom_range(0, 2) == 0, pick_addr(), DW'($urandom)); end
      if (!b_act && $urandom_range(0, 99) < 50)
        begin b_act = 1; set_b(1, $urandom_range(0, 2) == 0, pick_addr(), DW'($urandom)); end
      a_bus.req = a_act;
      b_bus.req = b_act;
      a0_bus.req = ($urandom_range(0, 9) != 0);
      b0_bus.req = ($urandom_range(0, 3) != 0);
      step();
      if (last_ea) a_act = 0;
      if (last_eb) b_act = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous main RAM (1-cycle read latency) between two bus masters.
  - Port A: the 6502 CPU, high priority.
  - Port B: a secondary master such as a DMA/loader engine or video fetch, low priority with starvation protection.
- Sits between the masters and the RAM in the SoC top level.
- Produces the per-master grant, read-valid and stall signals; a_stall gates the CPU RDY input.

Parameters:
- ADDR_WIDTH, 15, RAM address width (32KB).
- DATA_WIDTH, 8, data bus width.
- STARVE_LIMIT, 8, number of consecutive lost cycles after which B beats A for one grant; 0 = A strict priority, B may starve.

Ports:
- clk  input  1  system clock (25 MHz); only clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_req  input  1  A request, level; held with a_we/a_addr/a_wdata stable until a_gnt sampled high.
- a_we  input  1  A write (1) / read (0).
- a_addr  input  ADDR_WIDTH  A address.
- a_wdata  input  DATA_WIDTH  A write data.
- a_gnt  output  1  A access issued to RAM this cycle (combinational).
- a_rvalid  output  1  A read data valid (registered, 1 cycle after read grant).
- a_rdata  output  DATA_WIDTH  A read data; mem_rdata when a_rvalid, else 0.
- a_stall  output  1  a_req & ~a_gnt; drives CPU RDY low.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical semantics for master B.
- mem_en  output  1  RAM access strobe.
- mem_we  output  1  RAM write enable (only with mem_en).
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_wdata  output  DATA_WIDTH  RAM write data.
- mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after a read strobe.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Arbitration each cycle (combinational from inputs and registered state):
  - starve_hit = (STARVE_LIMIT != 0) && (wait_cnt == STARVE_LIMIT).
  - B wins if b_req && (!a_req || starve_hit).
  - Otherwise A wins if a_req.
  - Otherwise no grant.
- Exactly one of a_gnt/b_gnt is high when any request is present and rst is low. Never both.
- Memory bus:
  - mem_en = a_gnt | b_gnt.
  - mem_we / mem_addr / mem_wdata muxed from the winner.
  - With no winner, all mem_* outputs are 0.
- Read return:
  - A registered owner tag {NONE, A, B} is loaded each cycle with the winner if the granted access is a read, else NONE.
  - a_rvalid = (owner == A); b_rvalid = (owner == B).
  - Back-to-back reads give one rvalid per cycle, tagged correctly.
- Writes: complete at grant; no rvalid is generated.
- wait_cnt (width clog2(STARVE_LIMIT+1), min 1):
  - Increments when b_req && !b_gnt, saturating at STARVE_LIMIT.
  - Clears when b_gnt or !b_req.
  - After an override grant, A regains priority the next cycle.
- Simultaneous events:
  - A and B both request with no starvation: A granted, B stalls, wait_cnt increments.
  - Master A requests every cycle: B is granted exactly once every STARVE_LIMIT+1 cycles.
- Reset:
  - While rst is high: a_gnt=b_gnt=0 and mem_en=0, regardless of requests.
  - Next edge: owner=NONE, wait_cnt=0.
  - All outputs are 0 from the first cycle after reset is sampled, except a_stall/b_stall, which follow a_req/b_req.
  - An in-flight read whose data would return the cycle after rst assertion is dropped (no rvalid).
- No combinational path from mem_rdata to any grant.
- No path from rvalid to any request.

Decomposition:
- Shared package mem_arb_pkg:
  - Owner encoding localparams OWNER_NONE=2'd0, OWNER_A=2'd1, OWNER_B=2'd2.
  - Default DATA_WIDTH/ADDR_WIDTH constants shared with ram.
- Single flat module; no sub-module needed. The starvation counter and owner tag are small enough to stay inline.

Test Plan:
- Reset with a_req=b_req=1 held -> a_gnt=b_gnt=0, mem_en=0 throughout rst; after release, first cycle a_gnt=1.
- A read $1234 alone, RAM preloaded $1234=$5A -> a_gnt cycle N with mem_addr=$1234, mem_we=0; a_rvalid=1 and a_rdata=$5A at N+1; b_rvalid stays 0.
- Both requesting continuously, STARVE_LIMIT=8 -> 8 A grants then 1 B grant, repeating; B grant period exactly 9 cycles; a_stall=1 only on B-grant cycles.
- Alternating A read $0010 / B read $0020 back-to-back ($0010=$11, $0020=$22) -> rvalid tags alternate with no loss: a_rdata=$11 and b_rdata=$22 on the correct cycles.
- B write $7FFF=$A5 then A read $7FFF -> b_gnt with mem_we=1, no b_rvalid; the A read returns $A5 (address wrap at top of 15-bit space unaffected).
- A read granted, rst asserted the next cycle -> no a_rvalid; owner=NONE, wait_cnt=0 after reset; STARVE_LIMIT=0 build: B never granted while a_req=1.
